// File: rtl/rob_ctrl.sv
// rob_ctrl: central controller for the reorder buffer.
// Allocates entries in program order at the tail, retires entries in order
// from the head and turns each accepted commit into one registered
// register-file write. An entry that commits out of turn sets a sticky
// protocol error and is otherwise ignored.
module rob_ctrl #(
  parameter int NUM_ENTRIES = 8,
  parameter int PTR_W       = 3,
  parameter int DATA_W      = 32,
  parameter int RS_W        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          alloc_req,
  input  logic [RS_W-1:0]               alloc_rs_idx,
  output logic                          alloc_ready,
  output logic [PTR_W-1:0]              alloc_tag,
  output logic [NUM_ENTRIES-1:0]        sel,
  output logic [RS_W-1:0]               sel_rs_idx,
  output logic [PTR_W-1:0]              head,
  input  logic [NUM_ENTRIES-1:0]        entry_wen,
  input  logic [5*NUM_ENTRIES-1:0]      entry_dest,
  input  logic [DATA_W*NUM_ENTRIES-1:0] entry_val,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [PTR_W:0]                count,
  output logic                          full,
  output logic                          empty,
  output logic                          protocol_err
);

  localparam logic [PTR_W:0]       FULL_COUNT = (PTR_W+1)'(NUM_ENTRIES);
  localparam logic [PTR_W:0]       ZERO_COUNT = {(PTR_W+1){1'b0}};
  localparam logic [NUM_ENTRIES-1:0] ONE_OH   = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};
  localparam logic [NUM_ENTRIES-1:0] NO_OH    = {NUM_ENTRIES{1'b0}};

  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W:0]    count_r;
  logic              rf_we_r;
  logic [4:0]        rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic              protocol_err_r;

  logic                   full_s;
  logic                   empty_s;
  logic                   alloc_fire_s;
  logic                   commit_s;
  logic                   viol_s;
  logic [NUM_ENTRIES-1:0] head_oh_s;
  logic [NUM_ENTRIES-1:0] sel_s;
  logic [4:0]             head_dest_s;
  logic [DATA_W-1:0]      head_val_s;

  // Unflattened per-entry commit payloads so the head entry can be picked directly.
  logic [4:0]        dest_arr_s [NUM_ENTRIES];
  logic [DATA_W-1:0] val_arr_s  [NUM_ENTRIES];

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_unpack
    assign dest_arr_s[g] = entry_dest[5*g +: 5];
    assign val_arr_s[g]  = entry_val[DATA_W*g +: DATA_W];
  end

  // Occupancy flags, allocation/commit qualification and protocol violation detect.
  always_comb begin
    full_s       = (count_r == FULL_COUNT);
    empty_s      = (count_r == ZERO_COUNT);
    alloc_fire_s = alloc_req && !full_s && !flush;
    head_oh_s    = ONE_OH << head_r;
    commit_s     = ((entry_wen & head_oh_s) != NO_OH) && !empty_s;
    viol_s       = ((entry_wen & ~head_oh_s) != NO_OH) ||
                   (((entry_wen & head_oh_s) != NO_OH) && empty_s);
    head_dest_s  = dest_arr_s[head_r];
    head_val_s   = val_arr_s[head_r];
    if (alloc_fire_s) begin
      sel_s = ONE_OH << tail_r;
    end else begin
      sel_s = NO_OH;
    end
  end

  // Pointer, occupancy, register-file write port and sticky error state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r         <= {PTR_W{1'b0}};
      tail_r         <= {PTR_W{1'b0}};
      count_r        <= ZERO_COUNT;
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= 5'd0;
      rf_wdata_r     <= {DATA_W{1'b0}};
      protocol_err_r <= 1'b0;
    end else if (flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= ZERO_COUNT;
      rf_we_r <= 1'b0;
    end else begin
      if (alloc_fire_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (commit_s) begin
        head_r     <= head_r + PTR_W'(1);
        rf_waddr_r <= head_dest_s;
        rf_wdata_r <= head_val_s;
        rf_we_r    <= (head_dest_s != 5'd0);
      end else begin
        rf_we_r <= 1'b0;
      end
      case ({alloc_fire_s, commit_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
      if (viol_s) begin
        protocol_err_r <= 1'b1;
      end
    end
  end

  assign alloc_ready  = !full_s;
  assign alloc_tag    = tail_r;
  assign sel          = sel_s;
  assign sel_rs_idx   = alloc_rs_idx;
  assign head         = head_r;
  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign protocol_err = protocol_err_r;

endmodule

// File: tb/tb_rob_ctrl.sv
// Testbench for rob_ctrl: directed scenarios plus a randomized run, all
// compared against an occupancy/pointer model kept in plain integers.
module tb_rob_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         alloc_req = 1'b0;
  logic [3:0]   alloc_rs_idx = 4'd0;
  logic         alloc_ready;
  logic [2:0]   alloc_tag;
  logic [7:0]   sel;
  logic [3:0]   sel_rs_idx;
  logic [2:0]   head;
  logic [7:0]   entry_wen = 8'd0;
  logic [39:0]  entry_dest = 40'd0;
  logic [255:0] entry_val = 256'd0;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [3:0]   count;
  logic         full;
  logic         empty;
  logic         protocol_err;

  int checks = 0;
  int errors = 0;

  logic [4:0]  dest_a [8];
  logic [31:0] val_a  [8];

  // Reference model state
  int          m_head = 0;
  int          m_tail = 0;
  int          m_count = 0;
  bit          m_perr = 1'b0;
  bit          m_rf_we = 1'b0;
  logic [4:0]  m_rf_waddr = 5'd0;
  logic [31:0] m_rf_wdata = 32'd0;

  rob_ctrl #(.NUM_ENTRIES(8), .PTR_W(3), .DATA_W(32), .RS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_req(alloc_req), .alloc_rs_idx(alloc_rs_idx),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .sel(sel), .sel_rs_idx(sel_rs_idx), .head(head),
    .entry_wen(entry_wen), .entry_dest(entry_dest), .entry_val(entry_val),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .count(count), .full(full), .empty(empty), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_sel();
    logic [7:0] one;
    one = 8'd1;
    if (alloc_req && m_count < 8 && !flush) return one << m_tail;
    return 8'd0;
  endfunction

  function automatic logic [7:0] head_bit();
    logic [7:0] one;
    one = 8'd1;
    return one << m_head;
  endfunction

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic setup(input bit req, input logic [3:0] rs, input logic [7:0] wen, input bit fl);
    alloc_req = req;
    alloc_rs_idx = rs;
    entry_wen = wen;
    flush = fl;
    for (int i = 0; i < 8; i++) begin
      entry_dest[5*i +: 5] = dest_a[i];
      entry_val[32*i +: 32] = val_a[i];
    end
    #1;
  endtask

  // Advance the model by the rules, then the DUT by one clock; return inputs to idle.
  task automatic tick();
    bit alc, acc, viol;
    if (!rst_n) begin
      m_head = 0; m_tail = 0; m_count = 0; m_perr = 1'b0;
      m_rf_we = 1'b0; m_rf_waddr = 5'd0; m_rf_wdata = 32'd0;
    end else if (flush) begin
      m_head = 0; m_tail = 0; m_count = 0; m_rf_we = 1'b0;
    end else begin
      alc = alloc_req && (m_count < 8);
      acc = entry_wen[m_head] && (m_count > 0);
      viol = 1'b0;
      for (int i = 0; i < 8; i++) if (entry_wen[i] && i != m_head) viol = 1'b1;
      if (entry_wen[m_head] && m_count == 0) viol = 1'b1;
      if (viol) m_perr = 1'b1;
      m_rf_we = 1'b0;
      if (acc) begin
        m_rf_waddr = dest_a[m_head];
        m_rf_wdata = val_a[m_head];
        m_rf_we = (dest_a[m_head] != 5'd0);
        m_head = (m_head + 1) % 8;
        m_count = m_count - 1;
      end
      if (alc) begin
        m_tail = (m_tail + 1) % 8;
        m_count = m_count + 1;
      end
    end
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    entry_wen = 8'd0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    setup(1'b0, 4'd0, 8'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || protocol_err !== 1'b0 || alloc_tag !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: waddr=%0d wdata=%h perr=%b tag=%0d, required 0 0 0 0",
               rf_waddr, rf_wdata, protocol_err, alloc_tag);
    end
    for (int c = 0; c < 10; c++) begin
      setup(1'b0, 4'd0, 8'd0, 1'b0);
      checks++;
      if (count !== 4'd0 || empty !== 1'b1 || alloc_ready !== 1'b1 || head !== 3'd0 ||
          rf_we !== 1'b0 || full !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c%0d: count=%0d empty=%b ready=%b head=%0d rf_we=%b full=%b, required 0 1 1 0 0 0",
                 c, count, empty, alloc_ready, head, rf_we, full);
      end
      tick();
    end
  endtask

  task automatic test_fill();
    logic [7:0] one;
    one = 8'd1;
    for (int i = 0; i < 8; i++) begin
      setup(1'b1, 4'(i + 1), 8'd0, 1'b0);
      checks++;
      if (sel !== (one << i) || sel_rs_idx !== 4'(i + 1) || alloc_tag !== 3'(i)) begin
        errors++;
        $display("FAIL fill_sel %0d: sel=%h rs=%0d tag=%0d, required %h %0d %0d",
                 i, sel, sel_rs_idx, alloc_tag, one << i, i + 1, i);
      end
      tick();
    end
    checks++;
    if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("FAIL fill_full: full=%b ready=%b count=%0d, required 1 0 8", full, alloc_ready, count);
    end
    setup(1'b1, 4'd9, 8'd0, 1'b0);
    checks++;
    if (sel !== 8'd0) begin
      errors++;
      $display("FAIL ninth_sel: sel=%h, required 00", sel);
    end
    tick();
    checks++;
    if (alloc_tag !== 3'd0 || count !== 4'd8) begin
      errors++;
      $display("FAIL ninth_tail: tag=%0d count=%0d, required 0 8", alloc_tag, count);
    end
  endtask

  task automatic test_commit_full();
    dest_a[0] = 5'd5;
    val_a[0] = 32'hDEADBEEF;
    setup(1'b0, 4'd0, 8'h01, 1'b0);
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || head !== 3'd1 || count !== 4'd7) begin
      errors++;
      $display("FAIL commit_full: we=%b waddr=%0d wdata=%h head=%0d count=%0d, required 1 5 deadbeef 1 7",
               rf_we, rf_waddr, rf_wdata, head, count);
    end
    setup(1'b0, 4'd0, 8'd0, 1'b0);
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL rf_we_pulse: we=%b, required 0", rf_we);
    end
  endtask

  task automatic test_protocol();
    dest_a[1] = 5'd7;
    setup(1'b0, 4'd0, 8'h02, 1'b0);
    tick();
    setup(1'b0, 4'd0, 8'h10, 1'b0);
    tick();
    checks++;
    if (rf_we !== 1'b0 || head !== 3'd2 || protocol_err !== 1'b1 || count !== 4'd6) begin
      errors++;
      $display("FAIL out_of_turn: we=%b head=%0d perr=%b count=%0d, required 0 2 1 6",
               rf_we, head, protocol_err, count);
    end
    dest_a[2] = 5'd3;
    val_a[2] = 32'h12345678;
    setup(1'b0, 4'd0, 8'h04, 1'b0);
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || head !== 3'd3 || protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL perr_sticky: we=%b waddr=%0d head=%0d perr=%b, required 1 3 3 1",
               rf_we, rf_waddr, head, protocol_err);
    end
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 2; k++) begin
      setup(1'b0, 4'd0, head_bit(), 1'b0);
      tick();
    end
    checks++;
    if (count !== 4'd3 || head !== 3'd5) begin
      errors++;
      $display("FAIL pre_same: count=%0d head=%0d, required 3 5", count, head);
    end
    setup(1'b1, 4'd2, head_bit(), 1'b0);
    tick();
    checks++;
    if (count !== 4'd3 || head !== 3'd6 || alloc_tag !== 3'd1) begin
      errors++;
      $display("FAIL same_cycle: count=%0d head=%0d tail=%0d, required 3 6 1", count, head, alloc_tag);
    end
  endtask

  task automatic test_x0();
    dest_a[6] = 5'd0;
    setup(1'b0, 4'd0, head_bit(), 1'b0);
    tick();
    checks++;
    if (rf_we !== 1'b0 || head !== 3'd7 || count !== 4'd2) begin
      errors++;
      $display("FAIL x0_commit: we=%b head=%0d count=%0d, required 0 7 2", rf_we, head, count);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      setup(1'b1, 4'(k), 8'd0, 1'b0);
      tick();
    end
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL pre_flush: count=%0d, required 5", count);
    end
    dest_a[7] = 5'd9;
    setup(1'b1, 4'd3, head_bit(), 1'b1);
    checks++;
    if (sel !== 8'd0) begin
      errors++;
      $display("FAIL flush_sel: sel=%h, required 00", sel);
    end
    tick();
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || head !== 3'd0 || alloc_tag !== 3'd0 ||
        rf_we !== 1'b0 || protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d empty=%b head=%0d tag=%0d we=%b perr=%b, required 0 1 0 0 0 1",
               count, empty, head, alloc_tag, rf_we, protocol_err);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] d;
    for (int k = 0; k < 20; k++) begin
      setup(1'b1, 4'($urandom_range(15)), 8'd0, 1'b0);
      tick();
      d = 5'($urandom_range(31, 1));
      dest_a[m_head] = d;
      val_a[m_head] = $urandom;
      setup(1'b0, 4'd0, head_bit(), 1'b0);
      tick();
      checks++;
      if (head !== 3'((k + 1) % 8) || alloc_tag !== 3'((k + 1) % 8) || count !== 4'd0 ||
          rf_we !== 1'b1 || rf_waddr !== d) begin
        errors++;
        $display("FAIL wrap %0d: head=%0d tail=%0d count=%0d we=%b waddr=%0d, required %0d %0d 0 1 %0d",
                 k, head, alloc_tag, count, rf_we, rf_waddr, (k + 1) % 8, (k + 1) % 8, d);
      end
    end
  endtask

  task automatic test_random();
    bit req, fl;
    logic [3:0] rs;
    logic [7:0] wen;
    int r;
    for (int c = 0; c < 500; c++) begin
      rst_n = ($urandom_range(79) != 0);
      for (int i = 0; i < 8; i++) begin
        dest_a[i] = 5'($urandom_range(31));
        val_a[i] = $urandom;
      end
      req = ($urandom_range(1) == 1);
      rs = 4'($urandom_range(15));
      fl = ($urandom_range(29) == 0);
      r = $urandom_range(19);
      if (r < 10) wen = head_bit();
      else if (r == 10) wen = 8'($urandom_range(255));
      else wen = 8'd0;
      setup(req, rs, wen, fl);
      checks++;
      if (sel !== m_sel() || alloc_ready !== (m_count < 8) || alloc_tag !== 3'(m_tail) || sel_rs_idx !== rs) begin
        errors++;
        $display("FAIL rand_comb c%0d: sel=%h ready=%b tag=%0d rs=%0d, required %h %b %0d %0d",
                 c, sel, alloc_ready, alloc_tag, sel_rs_idx, m_sel(), m_count < 8, m_tail, rs);
      end
      tick();
      rst_n = 1'b1;
      checks++;
      if (head !== 3'(m_head) || count !== 4'(m_count) || full !== (m_count == 8) ||
          empty !== (m_count == 0) || rf_we !== m_rf_we || rf_waddr !== m_rf_waddr ||
          rf_wdata !== m_rf_wdata || protocol_err !== m_perr) begin
        errors++;
        $display("FAIL rand_state c%0d: head=%0d count=%0d full=%b empty=%b we=%b waddr=%0d wdata=%h perr=%b, required %0d %0d %b %b %b %0d %h %b",
                 c, head, count, full, empty, rf_we, rf_waddr, rf_wdata, protocol_err,
                 m_head, m_count, m_count == 8, m_count == 0, m_rf_we, m_rf_waddr, m_rf_wdata, m_perr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      dest_a[i] = 5'd1;
      val_a[i] = 32'd0;
    end
    test_reset();
    test_fill();
    test_commit_full();
    test_protocol();
    test_same_cycle();
    test_x0();
    test_flush();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
